// File: rtl/run_controller_if.sv
// Host program-load channel: valid/ready handshake carrying one 9-bit
// instruction word and its instruction memory address.
interface run_controller_if #(
  parameter int ADDR_W = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [8:0]        load_data;

  modport master (
    output load_valid, load_addr, load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_addr, load_data,
    output load_ready
  );
endinterface

// File: rtl/run_controller.sv
// Launch sequencer: loads program words into instruction memory, pulses the
// processor start input, then watches Halt with an optional cycle watchdog.
module run_controller #(
  parameter int START_CYCLES = 2,
  parameter int ADDR_W       = 8
) (
  input  logic               CLK,
  input  logic               reset_n,
  run_controller_if.slave    load,
  input  logic               go,
  input  logic [31:0]        timeout_limit,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [8:0]         imem_wdata,
  output logic               start,
  input  logic               Halt,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [31:0]        cycle_count,
  output logic [ADDR_W:0]    load_count
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam logic [3:0]      START_LAST = 4'(START_CYCLES - 1);
  localparam logic [ADDR_W:0] LOAD_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LOAD_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [3:0] start_cnt;
  logic       accept;
  logic       timeout_hit;

  // load_ready is gated by reset_n so the host never sees ready mid-reset.
  assign load.load_ready = reset_n && (state == IDLE);
  assign accept          = load.load_valid && load.load_ready;
  assign busy            = (state == START) || (state == RUN);
  assign timeout_hit     = (timeout_limit != 32'd0) && (cycle_count == timeout_limit);

  always_ff @(posedge CLK) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A load handshake in the same cycle as go takes priority; go is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go && !accept)            state_nxt = START;
      START:   if (start_cnt == START_LAST)  state_nxt = RUN;
      RUN:     if (Halt || timeout_hit)      state_nxt = DONE;
      DONE:                                  state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      start       <= 1'b0;
      done        <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
      load_count  <= '0;
      start_cnt   <= '0;
    end else begin
      start   <= (state_nxt == START);
      done    <= (state_nxt == DONE);
      imem_we <= accept;

      if (accept) begin
        imem_addr  <= load.load_addr;
        imem_wdata <= load.load_data;
        if (load_count != LOAD_MAX) load_count <= load_count + LOAD_ONE;
      end

      if (state == START) start_cnt <= start_cnt + 4'd1;
      else                start_cnt <= '0;

      // Halt has priority over the watchdog; neither advances the count.
      if (state == IDLE && state_nxt == START) begin
        cycle_count <= '0;
        timed_out   <= 1'b0;
      end else if (state == RUN && !Halt) begin
        if (timeout_hit) timed_out   <= 1'b1;
        else             cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Scenario bench for run_controller: expected imem writes are queued at the
// handshake and popped by a monitor; run behaviour is checked per scenario.
module tb_run_controller;
  localparam int SC = 2;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic          Halt = 1'b0;
  logic [31:0]   timeout_limit = '0;
  logic          imem_we, start, busy, done, timed_out;
  logic [AW-1:0] imem_addr;
  logic [8:0]    imem_wdata;
  logic [31:0]   cycle_count;
  logic [AW:0]   load_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_wr;

  always #5 CLK = ~CLK;

  run_controller_if #(.ADDR_W(AW)) lif ();

  run_controller #(.START_CYCLES(SC), .ADDR_W(AW)) dut (
    .CLK(CLK), .reset_n(reset_n), .load(lif.slave), .go(go),
    .timeout_limit(timeout_limit), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .start(start), .Halt(Halt), .busy(busy),
    .done(done), .timed_out(timed_out), .cycle_count(cycle_count),
    .load_count(load_count)
  );

  // Every write strobe must match the oldest outstanding accepted word.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h expected none", imem_addr, imem_wdata);
      end else begin
        exp_wr = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp_wr) begin
          failures++;
          $display("FAIL write_content got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, exp_wr.addr, exp_wr.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_once(input int halt_after, input logic [31:0] limit,
                          output logic first_start, output int starts, output bit got_done);
    int run_n;
    run_n = 0;
    starts = 0;
    got_done = 0;
    timeout_limit = limit;
    Halt = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    first_start = start;
    for (int k = 0; k < 200; k++) begin
      if (start) starts++;
      if (done) begin
        got_done = 1;
        break;
      end
      if (busy && !start) begin
        run_n++;
        Halt = (halt_after >= 0) && (run_n > halt_after);
      end else begin
        Halt = 1'b0;
      end
      tick();
    end
    Halt = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_addr = '0;
    lif.load_data = '0;
    repeat (3) tick();
    checks++;
    if ({start, imem_we, imem_addr, imem_wdata, done, timed_out, cycle_count,
         load_count, busy, lif.load_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs start=%b we=%b done=%b to=%b cc=%0d lc=%0d busy=%b ready=%b expected all 0",
               start, imem_we, done, timed_out, cycle_count, load_count, busy, lif.load_ready);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (lif.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b expected 1", lif.load_ready);
    end
  endtask

  task automatic test_load();
    logic [8:0] data_tab [3];
    data_tab[0] = 9'h1A3;
    data_tab[1] = 9'h0FF;
    data_tab[2] = 9'h100;
    for (int i = 0; i < 3; i++) begin
      lif.load_valid = 1'b1;
      lif.load_addr = AW'(i);
      lif.load_data = data_tab[i];
      if (lif.load_ready) exp_q.push_back({lif.load_addr, lif.load_data});
      tick();
      checks++;
      if (imem_we !== 1'b1) begin
        failures++;
        $display("FAIL load_we_word%0d got %b expected 1", i, imem_we);
      end
    end
    lif.load_valid = 1'b0;
    tick();
    checks++;
    if (imem_we !== 1'b0) begin
      failures++;
      $display("FAIL load_we_after got %b expected 0", imem_we);
    end
    checks++;
    if (load_count !== 9'd3) begin
      failures++;
      $display("FAIL load_count got %0d expected 3", load_count);
    end
  endtask

  task automatic test_run_halt();
    logic fs;
    int   starts;
    bit   got_done;
    run_once(10, 32'd0, fs, starts, got_done);
    checks++;
    if (fs !== 1'b1) begin failures++; $display("FAIL halt_start_latency got %b expected 1", fs); end
    checks++;
    if (starts != SC) begin failures++; $display("FAIL halt_start_width got %0d expected %0d", starts, SC); end
    checks++;
    if (!got_done) begin failures++; $display("FAIL halt_done got 0 expected 1"); end
    checks++;
    if (cycle_count !== 32'd10) begin failures++; $display("FAIL halt_cycle_count got %0d expected 10", cycle_count); end
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL halt_timed_out got %b expected 0", timed_out); end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL halt_after_done busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_timeout();
    logic fs;
    int   starts;
    bit   got_done;
    run_once(-1, 32'd5, fs, starts, got_done);
    checks++;
    if (!got_done || timed_out !== 1'b1 || cycle_count !== 32'd5) begin
      failures++;
      $display("FAIL timeout_fire done=%b to=%b cc=%0d expected 1 1 5", got_done, timed_out, cycle_count);
    end
    tick();
    run_once(5, 32'd5, fs, starts, got_done);
    checks++;
    if (!got_done || timed_out !== 1'b0 || cycle_count !== 32'd5) begin
      failures++;
      $display("FAIL timeout_halt_tie done=%b to=%b cc=%0d expected 1 0 5", got_done, timed_out, cycle_count);
    end
    tick();
    timeout_limit = '0;
  endtask

  task automatic test_go_and_load();
    lif.load_valid = 1'b1;
    lif.load_addr = 8'h03;
    lif.load_data = 9'h0AB;
    go = 1'b1;
    if (lif.load_ready) exp_q.push_back({lif.load_addr, lif.load_data});
    tick();
    lif.load_valid = 1'b0;
    go = 1'b0;
    checks++;
    if ({imem_we, busy, start, lif.load_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL go_load_same we=%b busy=%b start=%b ready=%b expected 1 0 0 1",
               imem_we, busy, start, lif.load_ready);
    end
    tick();
    checks++;
    if ({start, busy} !== 2'b00) begin
      failures++;
      $display("FAIL go_load_no_start start=%b busy=%b expected 0 0", start, busy);
    end
    checks++;
    if (load_count !== 9'd4) begin failures++; $display("FAIL go_load_count got %0d expected 4", load_count); end
  endtask

  task automatic test_load_during_run();
    bit in_run;
    in_run = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 20 && !in_run; k++) begin
      if (busy && !start) in_run = 1;
      else tick();
    end
    checks++;
    if (!in_run) begin failures++; $display("FAIL run_entry got no RUN state expected RUN"); end
    lif.load_valid = 1'b1;
    lif.load_addr = 8'h55;
    lif.load_data = 9'h1AA;
    checks++;
    if (lif.load_ready !== 1'b0) begin failures++; $display("FAIL run_ready got %b expected 0", lif.load_ready); end
    repeat (2) begin
      tick();
      checks++;
      if (imem_we !== 1'b0) begin failures++; $display("FAIL run_no_write got %b expected 0", imem_we); end
    end
    lif.load_valid = 1'b0;
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL run_halt_done got %b expected 1", done); end
    tick();
    checks++;
    if (load_count !== 9'd4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_load_count lc=%0d busy=%b expected 4 0", load_count, busy);
    end
  endtask

  task automatic test_reset_in_run();
    int   run_n;
    logic fs;
    int   starts;
    bit   got_done;
    run_n = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (busy && !start) run_n++;
      if (run_n == 4) break;
      tick();
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({start, busy, done, lif.load_ready} !== 4'b0000 || cycle_count !== 32'd0 || load_count !== '0) begin
      failures++;
      $display("FAIL reset_in_run start=%b busy=%b done=%b ready=%b cc=%0d lc=%0d expected all 0",
               start, busy, done, lif.load_ready, cycle_count, load_count);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({done, busy, lif.load_ready} !== 3'b001) begin
      failures++;
      $display("FAIL reset_in_run_after done=%b busy=%b ready=%b expected 0 0 1", done, busy, lif.load_ready);
    end
    run_once(3, 32'd0, fs, starts, got_done);
    checks++;
    if (!got_done || starts != SC || cycle_count !== 32'd3) begin
      failures++;
      $display("FAIL reset_rerun done=%b starts=%0d cc=%0d expected 1 %0d 3", got_done, starts, cycle_count, SC);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_timeout();
    test_go_and_load();
    test_load_during_run();
    test_reset_in_run();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_writes got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
